// File: rtl/in_packet_if.sv
// InBus beat interface for the packet chopper ingress: Val/Sop/Eop/Mod/Dat from the source, Rdy back.
// Mod carries the count of valid bytes on the Eop beat, counted from the most significant byte.
interface in_packet_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int BYTE_W = DATA_WIDTH / 8;
    localparam int MOD_W  = $clog2(BYTE_W) + 1;

    logic                  Val;
    logic                  Sop;
    logic                  Eop;
    logic [MOD_W-1:0]      Mod;
    logic [DATA_WIDTH-1:0] Dat;
    logic                  Rdy;

    modport master (output Val, Sop, Eop, Mod, Dat, input Rdy);
    modport slave  (input Val, Sop, Eop, Mod, Dat, output Rdy);
endinterface

// File: rtl/in_packet.sv
// in_packet: writes InBus packets word-by-word into the packet FIFO, zero-pads the Eop word,
// pulses InBus_Error on protocol/Mod/overflow faults. Define IN_PACKET_LEN_CHECK_EN to add the length-header check.
module in_packet #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  Clk,
    input  logic                  Rst,
    in_packet_if.slave            InBus,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic                  InBus_Error,
    output logic [15:0]           pkt_count
);
    localparam int BYTE_W = DATA_WIDTH / 8;
    localparam int MOD_W  = $clog2(BYTE_W) + 1;

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    state_t                state_q, state_d;
    logic                  fifo_wr_q, fifo_wr_d;
    logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic                  err_q, err_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic [15:0]           byte_cnt_q, byte_cnt_d;
`ifdef IN_PACKET_LEN_CHECK_EN
    logic [15:0]           total_len_q, total_len_d;
    logic [15:0]           len_ref;
`endif

    logic                  start_pkt, cont_pkt, mod_bad, len_bad;
    logic [MOD_W-1:0]      mod_eff;
    logic [15:0]           beat_bytes, cnt_next;

    // Keep the top n bytes, clear the rest (bytes arrive MSB-first).
    function automatic logic [DATA_WIDTH-1:0] mask_tail(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [MOD_W-1:0] n);
        logic [DATA_WIDTH-1:0] r;
        r = d;
        for (int i = 0; i < BYTE_W; i++)
            if (i < BYTE_W - int'(n)) r[8*i +: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign InBus.Rdy    = ~fifo_full & ~Rst;
    assign fifo_wr      = fifo_wr_q;
    assign fifo_data_in = fifo_data_q;
    assign InBus_Error  = err_q;
    assign pkt_count    = pkt_count_q;

    always_comb begin
        state_d     = state_q;
        fifo_wr_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        err_d       = 1'b0;
        pkt_count_d = pkt_count_q;
        byte_cnt_d  = byte_cnt_q;
        start_pkt   = 1'b0;
        cont_pkt    = 1'b0;
        len_bad     = 1'b0;
        cnt_next    = byte_cnt_q;
`ifdef IN_PACKET_LEN_CHECK_EN
        total_len_d = total_len_q;
        len_ref     = total_len_q;
`endif
        mod_bad    = InBus.Eop && (InBus.Mod == '0 || InBus.Mod > MOD_W'(BYTE_W));
        mod_eff    = mod_bad ? MOD_W'(BYTE_W) : InBus.Mod;
        beat_bytes = InBus.Eop ? 16'(mod_eff) : 16'(BYTE_W);

        // A full FIFO on a beat that would be written aborts the packet; the rest is discarded.
        if (InBus.Val) begin
            case (state_q)
                IDLE: begin
                    if (!InBus.Sop) begin
                        err_d = 1'b1;
                    end else if (fifo_full) begin
                        err_d   = 1'b1;
                        state_d = InBus.Eop ? IDLE : DROP;
                    end else begin
                        start_pkt = 1'b1;
                    end
                end
                BODY: begin
                    if (fifo_full) begin
                        err_d   = 1'b1;
                        state_d = InBus.Eop ? IDLE : DROP;
                    end else if (InBus.Sop) begin
                        err_d     = 1'b1;
                        start_pkt = 1'b1;
                    end else begin
                        cont_pkt = 1'b1;
                    end
                end
                DROP: begin
                    if (InBus.Sop && !fifo_full) begin
                        start_pkt = 1'b1;
                    end else if (InBus.Sop) begin
                        err_d   = 1'b1;
                        state_d = InBus.Eop ? IDLE : DROP;
                    end else if (InBus.Eop) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (start_pkt || cont_pkt) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = InBus.Eop ? mask_tail(InBus.Dat, mod_eff) : InBus.Dat;
            cnt_next    = start_pkt ? beat_bytes : sat_add(byte_cnt_q, beat_bytes);
            byte_cnt_d  = cnt_next;
`ifdef IN_PACKET_LEN_CHECK_EN
            if (start_pkt) begin
                total_len_d = InBus.Dat[DATA_WIDTH-1 -: 16];
                len_ref     = InBus.Dat[DATA_WIDTH-1 -: 16];
            end
            len_bad = InBus.Eop && ((cnt_next != len_ref) || (len_ref < 16'd2));
`endif
            if (InBus.Eop) begin
                state_d = IDLE;
                if (mod_bad || len_bad) err_d = 1'b1;
                else pkt_count_d = pkt_count_q + 16'd1;
            end else begin
                state_d = BODY;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
            err_q       <= 1'b0;
            pkt_count_q <= 16'd0;
            byte_cnt_q  <= 16'd0;
`ifdef IN_PACKET_LEN_CHECK_EN
            total_len_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_data_q <= fifo_data_d;
            err_q       <= err_d;
            pkt_count_q <= pkt_count_d;
            byte_cnt_q  <= byte_cnt_d;
`ifdef IN_PACKET_LEN_CHECK_EN
            total_len_q <= total_len_d;
`endif
        end
    end
endmodule

// File: tb/tb_in_packet.sv
// Bench for in_packet (64-bit): directed vector table, hand-written reset/overflow sequences,
// then random packet traffic scored against a packet-level reference model.
module tb_in_packet;
`ifdef IN_PACKET_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        fifo_full;
    logic        fifo_wr;
    logic [63:0] fifo_data_in;
    logic        InBus_Error;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    in_packet_if #(.DATA_WIDTH(64)) bus ();

    in_packet #(.DATA_WIDTH(64)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .InBus       (bus),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_data_in(fifo_data_in),
        .InBus_Error (InBus_Error),
        .pkt_count   (pkt_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          val, sop, eop;
        logic [3:0]  mod;
        logic [63:0] dat;
        bit          full;
        bit          wr;
        logic [63:0] data;
        bit          err;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit val, bit sop, bit eop, logic [3:0] mod, logic [63:0] dat, bit full,
                                bit wr, logic [63:0] data, bit err, logic [15:0] cnt);
        vec_t v;
        v.val = val; v.sop = sop; v.eop = eop; v.mod = mod; v.dat = dat; v.full = full;
        v.wr = wr; v.data = data; v.err = err; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one beat at posedge+1, check Rdy before the edge and the registered outputs after it.
    task automatic beat(input string name, input bit val, input bit sop, input bit eop,
                        input logic [3:0] mod, input logic [63:0] dat, input bit full,
                        input bit ewr, input logic [63:0] edat, input bit eerr, input logic [15:0] ecnt);
        bus.Val = val; bus.Sop = sop; bus.Eop = eop; bus.Mod = mod; bus.Dat = dat;
        fifo_full = full;
        #1;
        check({name, " rdy"}, 64'(bus.Rdy), 64'(!full));
        @(posedge Clk);
        #1;
        check({name, " wr"}, 64'(fifo_wr), 64'(ewr));
        if (ewr) check({name, " data"}, fifo_data_in, edat);
        check({name, " err"}, 64'(InBus_Error), 64'(eerr));
        check({name, " cnt"}, 64'(pkt_count), 64'(ecnt));
    endtask

    task automatic do_reset();
        bus.Val = 1'b0; bus.Sop = 1'b0; bus.Eop = 1'b0; bus.Mod = '0; bus.Dat = '0;
        fifo_full = 1'b0;
        Rst = 1'b1;
        #2;
        check("reset wr", 64'(fifo_wr), 64'd0);
        check("reset data", fifo_data_in, 64'd0);
        check("reset err", 64'(InBus_Error), 64'd0);
        check("reset cnt", 64'(pkt_count), 64'd0);
        check("reset rdy", 64'(bus.Rdy), 64'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    // Reference model: tracks whether a packet is open or being discarded, in plain integers.
    bit m_open, m_discard;
    int m_bytes, m_len, m_cnt;

    task automatic model(input bit val, input bit sop, input bit eop, input logic [3:0] mod,
                         input logic [63:0] dat, input bit full,
                         output bit wr, output logic [63:0] d, output bit err);
        bit first, modbad, lenbad;
        int n, sh;
        wr = 0; d = '0; err = 0; first = 0;
        if (!val) return;
        if (sop) begin
            if (m_open) err = 1;
            if (full) begin
                err = 1; m_open = 0; m_discard = !eop;
                return;
            end
            m_open = 0; m_discard = 0; first = 1;
        end else if (m_discard) begin
            if (eop) m_discard = 0;
            return;
        end else if (!m_open) begin
            err = 1;
            return;
        end else if (full) begin
            err = 1; m_open = 0; m_discard = !eop;
            return;
        end
        modbad = eop && (mod == 0 || mod > 8);
        n = !eop ? 8 : (modbad ? 8 : int'(mod));
        if (first) begin
            m_len = int'(dat[63:48]);
            m_bytes = n;
        end else begin
            m_bytes = (m_bytes + n > 65535) ? 65535 : m_bytes + n;
        end
        sh = 8 * (8 - n);
        wr = 1;
        d = (dat >> sh) << sh;
        if (eop) begin
            lenbad = LEN_EN && (m_bytes != m_len || m_len < 2);
            if (modbad || lenbad) err = 1;
            else m_cnt = (m_cnt + 1) % 65536;
            m_open = 0;
        end else begin
            m_open = 1;
        end
    endtask

    task automatic rnd_beat(input bit val, input bit sop, input bit eop, input logic [3:0] mod,
                            input logic [63:0] dat, input bit full);
        bit ewr, eerr;
        logic [63:0] ed;
        model(val, sop, eop, mod, dat, full, ewr, ed, eerr);
        beat("rnd", val, sop, eop, mod, dat, full, ewr, ed, eerr, 16'(m_cnt));
    endtask

    initial begin
        logic [15:0] c;
        #1;
        do_reset();

        tbl.push_back(mk(1,1,0,4'd0,64'h0014_1111_2222_3333,0, 1,64'h0014_1111_2222_3333,0,16'd0));
        tbl.push_back(mk(1,0,0,4'd0,64'h4444_5555_6666_7777,0, 1,64'h4444_5555_6666_7777,0,16'd0));
        tbl.push_back(mk(1,0,1,4'd4,64'h8888_9999_AAAA_BBBB,0, 1,64'h8888_9999_0000_0000,0,16'd1));
        tbl.push_back(mk(1,1,1,4'd6,64'h0006_ABCD_1234_5678,0, 1,64'h0006_ABCD_1234_0000,0,16'd2));
        tbl.push_back(mk(1,0,0,4'd0,64'hDEAD_BEEF_0000_0001,0, 0,64'd0,1,16'd2));
        tbl.push_back(mk(0,0,0,4'd0,64'd0,0, 0,64'd0,0,16'd2));
        tbl.push_back(mk(1,1,1,4'd0,64'h0008_0102_0304_0506,0, 1,64'h0008_0102_0304_0506,1,16'd2));
        tbl.push_back(mk(1,1,1,4'd9,64'h0008_A1A2_A3A4_A5A6,0, 1,64'h0008_A1A2_A3A4_A5A6,1,16'd2));
        tbl.push_back(mk(1,1,1,4'd2,64'h0002_FFFF_FFFF_FFFF,1, 0,64'd0,1,16'd2));
        tbl.push_back(mk(1,1,0,4'd0,64'h0020_0101_0202_0303,0, 1,64'h0020_0101_0202_0303,0,16'd2));
        tbl.push_back(mk(1,0,0,4'd0,64'h0404_0505_0606_0707,0, 1,64'h0404_0505_0606_0707,0,16'd2));
        tbl.push_back(mk(1,0,1,4'd4,64'h1234_5678_9ABC_DEF0,0, 1,64'h1234_5678_0000_0000,LEN_EN,
                         LEN_EN ? 16'd2 : 16'd3));
        tbl.push_back(mk(1,1,1,4'd2,64'h0001_2233_4455_6677,0, 1,64'h0001_0000_0000_0000,LEN_EN,
                         LEN_EN ? 16'd2 : 16'd4));

        foreach (tbl[i])
            beat($sformatf("vec%0d", i), tbl[i].val, tbl[i].sop, tbl[i].eop, tbl[i].mod, tbl[i].dat,
                 tbl[i].full, tbl[i].wr, tbl[i].data, tbl[i].err, tbl[i].cnt);
        c = tbl[tbl.size()-1].cnt;

        // Overflow on beat 2 of 4: the rest is discarded silently, the next packet is clean.
        beat("ovf b1", 1,1,0,4'd0,64'h0020_0000_0000_0001,0, 1,64'h0020_0000_0000_0001,0,c);
        beat("ovf b2", 1,0,0,4'd0,64'h2222_2222_2222_2222,1, 0,64'd0,1,c);
        beat("ovf b3", 1,0,0,4'd0,64'h3333_3333_3333_3333,0, 0,64'd0,0,c);
        beat("ovf b4", 1,0,1,4'd8,64'h4444_4444_4444_4444,0, 0,64'd0,0,c);
        beat("ovf nxt", 1,1,1,4'd8,64'h0008_5555_6666_7777,0, 1,64'h0008_5555_6666_7777,0,c + 16'd1);
        c = c + 16'd1;

        // Sop inside a packet: error for the old one, the new packet is kept and counted.
        beat("resop a", 1,1,0,4'd0,64'h0010_AAAA_AAAA_AAAA,0, 1,64'h0010_AAAA_AAAA_AAAA,0,c);
        beat("resop b", 1,1,0,4'd0,64'h0010_BBBB_BBBB_BBBB,0, 1,64'h0010_BBBB_BBBB_BBBB,1,c);
        beat("resop c", 1,0,1,4'd8,64'hCCCC_CCCC_CCCC_CCCC,0, 1,64'hCCCC_CCCC_CCCC_CCCC,0,c + 16'd1);

        // Asynchronous reset in the middle of a packet.
        beat("mid rst", 1,1,0,4'd0,64'h0018_0000_0000_0009,0, 1,64'h0018_0000_0000_0009,0,c + 16'd1);
        bus.Sop = 1'b0; bus.Dat = 64'h1111_0000_1111_0000;
        Rst = 1'b1;
        #2;
        check("arst wr", 64'(fifo_wr), 64'd0);
        check("arst err", 64'(InBus_Error), 64'd0);
        check("arst cnt", 64'(pkt_count), 64'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        beat("post rst", 1,1,1,4'd8,64'h0008_0123_4567_89AB,0, 1,64'h0008_0123_4567_89AB,0,16'd1);

        // Random traffic against the model.
        do_reset();
        m_open = 0; m_discard = 0; m_bytes = 0; m_len = 0; m_cnt = 0;
        for (int p = 0; p < 300; p++) begin
            int nb, gap, eff, total, hdr;
            logic [3:0] mod;
            bit trunc;
            nb  = $urandom_range(1, 5);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                rnd_beat(0, 1'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom}, 1'($urandom));
            if ($urandom_range(0, 19) == 0)
                rnd_beat(1, 0, 1'($urandom), 4'd8, {$urandom, $urandom}, 0);
            if ($urandom_range(0, 11) == 0)
                mod = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
            else
                mod = 4'($urandom_range(1, 8));
            eff   = (mod == 0 || mod > 8) ? 8 : int'(mod);
            total = 8 * (nb - 1) + eff;
            hdr   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 70) : total;
            trunc = (nb > 1) && ($urandom_range(0, 19) == 0);
            for (int b = 0; b < nb; b++) begin
                logic [63:0] dat;
                bit eop;
                dat = {$urandom, $urandom};
                if (b == 0) dat[63:48] = 16'(hdr);
                eop = (b == nb - 1) && !trunc;
                rnd_beat(1, b == 0, eop, eop ? mod : 4'($urandom), dat, $urandom_range(0, 9) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
